// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: ID operands and controls, WB bypass, flush, and registered EX outputs.
// The DUT uses the slave modport; the driver of ID/WB/flush uses master.
interface id_ex_pipe_reg_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 4
);
    logic                  id_valid;
    logic [DATA_W-1:0]     id_pc, id_rs_data, id_rt_data, id_imm;
    logic [REG_ADDR_W-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic                  id_ctrl_reg_write, id_ctrl_mem_read, id_ctrl_mem_write;
    logic                  id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;
    logic                  stall_out;
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs_addr, ex_rt_addr, ex_write_reg;
    logic                  ex_ctrl_reg_write, ex_ctrl_mem_read, ex_ctrl_mem_write;
    logic                  ex_ctrl_mem_to_reg, ex_ctrl_alu_src, ex_ctrl_reg_dst;
    logic [ALU_OP_W-1:0]   ex_alu_op;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr,
               id_ctrl_reg_write, id_ctrl_mem_read, id_ctrl_mem_write,
               id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst, id_alu_op,
               wb_reg_write, wb_write_reg, wb_data, flush,
        input  stall_out, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs_addr, ex_rt_addr, ex_write_reg,
               ex_ctrl_reg_write, ex_ctrl_mem_read, ex_ctrl_mem_write,
               ex_ctrl_mem_to_reg, ex_ctrl_alu_src, ex_ctrl_reg_dst, ex_alu_op
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr,
               id_ctrl_reg_write, id_ctrl_mem_read, id_ctrl_mem_write,
               id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst, id_alu_op,
               wb_reg_write, wb_write_reg, wb_data, flush,
        output stall_out, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs_addr, ex_rt_addr, ex_write_reg,
               ex_ctrl_reg_write, ex_ctrl_mem_read, ex_ctrl_mem_write,
               ex_ctrl_mem_to_reg, ex_ctrl_alu_src, ex_ctrl_reg_dst, ex_alu_op
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, branch flush bubble and WB->ID bypass.
// Optional PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 4
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    id_ex_pipe_reg_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic                  reg_dst;
        logic [ALU_OP_W-1:0]   alu_op;
    } ex_t;

    ex_t                   ex_q, ex_d;
    logic                  hazard, stall;
    logic                  rs_byp, rt_byp;
    logic [REG_ADDR_W-1:0] id_write_reg;

    // Load in EX whose rt is consumed by ID; rt only counts when ID reads it as operand B.
    always_comb begin
        hazard = ex_q.valid && ex_q.mem_read && bus.id_valid && (ex_q.rt_addr != '0) &&
                 ((ex_q.rt_addr == bus.id_rs_addr) ||
                  ((ex_q.rt_addr == bus.id_rt_addr) && !bus.id_ctrl_alu_src));
        stall  = hazard && !bus.flush;
    end

    always_comb begin
        rs_byp       = bus.wb_reg_write && (bus.wb_write_reg != '0) &&
                       (bus.wb_write_reg == bus.id_rs_addr);
        rt_byp       = bus.wb_reg_write && (bus.wb_write_reg != '0) &&
                       (bus.wb_write_reg == bus.id_rt_addr);
        id_write_reg = bus.id_ctrl_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;

        ex_d           = '0;
        ex_d.valid     = bus.id_valid;
        ex_d.pc        = bus.id_pc;
        ex_d.rs_data   = rs_byp ? bus.wb_data : bus.id_rs_data;
        ex_d.rt_data   = rt_byp ? bus.wb_data : bus.id_rt_data;
        ex_d.imm       = bus.id_imm;
        ex_d.rs_addr   = bus.id_rs_addr;
        ex_d.rt_addr   = bus.id_rt_addr;
        ex_d.write_reg = id_write_reg;
        if (bus.id_valid) begin
            // Writes to $0 are dropped here so later stages never see them.
            ex_d.reg_write  = bus.id_ctrl_reg_write && (id_write_reg != '0);
            ex_d.mem_read   = bus.id_ctrl_mem_read;
            ex_d.mem_write  = bus.id_ctrl_mem_write;
            ex_d.mem_to_reg = bus.id_ctrl_mem_to_reg;
            ex_d.alu_src    = bus.id_ctrl_alu_src;
            ex_d.reg_dst    = bus.id_ctrl_reg_dst;
            ex_d.alu_op     = bus.id_alu_op;
        end
        if (bus.flush || hazard) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, bus.flush};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    assign bus.stall_out          = stall;
    assign bus.ex_valid           = ex_q.valid;
    assign bus.ex_pc              = ex_q.pc;
    assign bus.ex_rs_data         = ex_q.rs_data;
    assign bus.ex_rt_data         = ex_q.rt_data;
    assign bus.ex_imm             = ex_q.imm;
    assign bus.ex_rs_addr         = ex_q.rs_addr;
    assign bus.ex_rt_addr         = ex_q.rt_addr;
    assign bus.ex_write_reg       = ex_q.write_reg;
    assign bus.ex_ctrl_reg_write  = ex_q.reg_write;
    assign bus.ex_ctrl_mem_read   = ex_q.mem_read;
    assign bus.ex_ctrl_mem_write  = ex_q.mem_write;
    assign bus.ex_ctrl_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_ctrl_alu_src    = ex_q.alu_src;
    assign bus.ex_ctrl_reg_dst    = ex_q.reg_dst;
    assign bus.ex_alu_op          = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed cases plus random traffic against a
// behavioural model of the ID/EX register. Define PIPE_PERF_CNT_EN to also check counters.
module tb_id_ex_pipe_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .ALU_OP_W(4)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    id_ex_pipe_reg #(
        .DATA_W    (32),
        .REG_ADDR_W(5),
        .ALU_OP_W  (4)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W     (32)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of what EX should hold; ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    logic        m_valid;
    logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_rs, m_rt, m_wr;
    logic [5:0]  m_ctrl;
    logic [3:0]  m_alu;
    logic [31:0] m_scnt, m_fcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_hazard();
        logic uses_load;
        uses_load = (m_rt == bus.id_rs_addr) || (m_rt == bus.id_rt_addr && !bus.id_ctrl_alu_src);
        return m_valid && m_ctrl[4] && bus.id_valid && m_rt != 0 && uses_load;
    endfunction

    task automatic model_step();
        logic haz;
        logic [4:0] wr;
        haz = m_hazard();
        if (reset) begin
            {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wr, m_ctrl, m_alu} = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (bus.flush) m_fcnt = m_fcnt + 1;
            if (haz && !bus.flush) m_scnt = m_scnt + 1;
            if (bus.flush || haz) begin
                {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wr, m_ctrl, m_alu} = '0;
            end else begin
                wr        = bus.id_ctrl_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
                m_valid   = bus.id_valid;
                m_pc      = bus.id_pc;
                m_imm     = bus.id_imm;
                m_rs      = bus.id_rs_addr;
                m_rt      = bus.id_rt_addr;
                m_wr      = wr;
                m_rs_data = (bus.wb_reg_write && bus.wb_write_reg != 0 &&
                             bus.wb_write_reg == bus.id_rs_addr) ? bus.wb_data : bus.id_rs_data;
                m_rt_data = (bus.wb_reg_write && bus.wb_write_reg != 0 &&
                             bus.wb_write_reg == bus.id_rt_addr) ? bus.wb_data : bus.id_rt_data;
                if (bus.id_valid) begin
                    m_ctrl = {bus.id_ctrl_reg_write && wr != 0, bus.id_ctrl_mem_read,
                              bus.id_ctrl_mem_write, bus.id_ctrl_mem_to_reg,
                              bus.id_ctrl_alu_src, bus.id_ctrl_reg_dst};
                    m_alu  = bus.id_alu_op;
                end else begin
                    m_ctrl = '0;
                    m_alu  = '0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", bus.ex_valid, m_valid);
        check("ex_pc", bus.ex_pc, m_pc);
        check("ex_rs_data", bus.ex_rs_data, m_rs_data);
        check("ex_rt_data", bus.ex_rt_data, m_rt_data);
        check("ex_imm", bus.ex_imm, m_imm);
        check("ex_addrs", {bus.ex_rs_addr, bus.ex_rt_addr, bus.ex_write_reg}, {m_rs, m_rt, m_wr});
        check("ex_ctrl", {bus.ex_ctrl_reg_write, bus.ex_ctrl_mem_read, bus.ex_ctrl_mem_write,
                          bus.ex_ctrl_mem_to_reg, bus.ex_ctrl_alu_src, bus.ex_ctrl_reg_dst},
              m_ctrl);
        check("ex_alu_op", bus.ex_alu_op, m_alu);
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt", stall_cnt, m_scnt);
        check("flush_cnt", flush_cnt, m_fcnt);
`endif
    endtask

    // Called just after a negedge with inputs applied; returns just after the next negedge.
    task automatic cycle(input logic chk_stall);
        #1;
        if (chk_stall) check("stall_out", bus.stall_out, m_hazard() && !bus.flush);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [5:0] ctrl, input logic [3:0] op);
        bus.id_valid   = v;
        bus.id_pc      = 32'h0000_0100;
        bus.id_imm     = 32'h0000_0010;
        bus.id_rs_addr = rs;
        bus.id_rt_addr = rt;
        bus.id_rd_addr = rd;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
        {bus.id_ctrl_reg_write, bus.id_ctrl_mem_read, bus.id_ctrl_mem_write,
         bus.id_ctrl_mem_to_reg, bus.id_ctrl_alu_src, bus.id_ctrl_reg_dst} = ctrl;
        bus.id_alu_op  = op;
    endtask

    task automatic clear_side();
        reset            = 1'b0;
        bus.flush        = 1'b0;
        bus.wb_reg_write = 1'b0;
        bus.wb_write_reg = '0;
        bus.wb_data      = '0;
    endtask

    localparam logic [5:0] CtlAdd = 6'b100001;
    localparam logic [5:0] CtlLw  = 6'b110110;

    initial begin
        {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wr, m_ctrl, m_alu} = '0;
        m_scnt = 0;
        m_fcnt = 0;
        clear_side();
        @(negedge clk);

        // Reset with every ID input high
        reset = 1'b1;
        set_id(1'b1, '1, '1, '1, '1, '1, '1, '1);
        bus.flush = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_write_reg = '1; bus.wb_data = '1;
        cycle(1'b0);
        cycle(1'b1);
        check("rst_valid", bus.ex_valid, 1'b0);
        check("rst_rs_data", bus.ex_rs_data, 32'd0);
        check("rst_stall", bus.stall_out, 1'b0);

        // Plain ADD capture
        clear_side();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, CtlAdd, 4'h2);
        cycle(1'b1);
        check("add_rs", bus.ex_rs_data, 32'd5);
        check("add_rt", bus.ex_rt_data, 32'd7);
        check("add_wr", bus.ex_write_reg, 5'd3);
        check("add_valid", bus.ex_valid, 1'b1);

        // Load-use stall for one cycle
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2, CtlLw, 4'h0);
        cycle(1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'd11, 32'd12, CtlAdd, 4'h2);
        #1 check("lu_stall", bus.stall_out, 1'b1);
        cycle(1'b1);
        check("lu_bubble", bus.ex_valid, 1'b0);
        check("lu_bub_mr", bus.ex_ctrl_mem_read, 1'b0);
        #1 check("lu_unstall", bus.stall_out, 1'b0);
        cycle(1'b1);
        check("lu_capture", bus.ex_valid, 1'b1);
        check("lu_rs_addr", bus.ex_rs_addr, 5'd8);

        // Hazard coinciding with flush
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2, CtlLw, 4'h0);
        cycle(1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'd11, 32'd12, CtlAdd, 4'h2);
        bus.flush = 1'b1;
        #1 check("fl_stall", bus.stall_out, 1'b0);
        cycle(1'b1);
        check("fl_bubble", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;
        #1 check("fl_nostall", bus.stall_out, 1'b0);
        cycle(1'b1);
        check("fl_capture", bus.ex_valid, 1'b1);

        // WB bypass, then the same against $0
        set_id(1'b1, 5'd1, 5'd9, 5'd4, 32'd1, 32'd0, CtlAdd, 4'h2);
        bus.wb_reg_write = 1'b1; bus.wb_write_reg = 5'd9; bus.wb_data = 32'h0000_DEAD;
        cycle(1'b1);
        check("byp_rt", bus.ex_rt_data, 32'h0000_DEAD);
        set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'd1, 32'd0, CtlAdd, 4'h2);
        bus.wb_write_reg = 5'd0;
        cycle(1'b1);
        check("byp_zero", bus.ex_rt_data, 32'd0);
        clear_side();

`ifdef PIPE_PERF_CNT_EN
        // Three load-use stalls and two flushes after a fresh reset
        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2, CtlLw, 4'h0);
            cycle(1'b1);
            set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'd11, 32'd12, CtlAdd, 4'h2);
            cycle(1'b1);
            cycle(1'b1);
        end
        bus.flush = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        bus.flush = 1'b0;
        check("perf_stall", stall_cnt, 32'd3);
        check("perf_flush", flush_cnt, 32'd2);
`endif

        // Random traffic with a narrow register range so hazards and bypasses are frequent
        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 63) == 0);
            bus.flush        = ($urandom_range(0, 7) == 0);
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_pc        = $urandom;
            bus.id_rs_data   = $urandom;
            bus.id_rt_data   = $urandom;
            bus.id_imm       = $urandom;
            bus.id_rs_addr   = 5'($urandom_range(0, 3));
            bus.id_rt_addr   = 5'($urandom_range(0, 3));
            bus.id_rd_addr   = 5'($urandom_range(0, 3));
            {bus.id_ctrl_reg_write, bus.id_ctrl_mem_write, bus.id_ctrl_mem_to_reg,
             bus.id_ctrl_alu_src, bus.id_ctrl_reg_dst} = 5'($urandom);
            bus.id_ctrl_mem_read = ($urandom_range(0, 1) == 0);
            bus.id_alu_op    = 4'($urandom);
            bus.wb_reg_write = $urandom_range(0, 1) == 1;
            bus.wb_write_reg = 5'($urandom_range(0, 3));
            bus.wb_data      = $urandom;
            cycle(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
